// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART TX write-port round-robin arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  // Width of a counter that can hold 0..max_burst without wrapping.
  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1, wrapping
// modulo NUM_REQ, and returns the first valid requester.
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_valid
);

  int cand;

  // Priority search starting just after the previous winner.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (!any_valid && req_valid[cand]) begin
        winner_oh[cand] = 1'b1;
        winner_idx      = IDX_W'(cand);
        any_valid       = 1'b1;
      end else begin
        any_valid = any_valid;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the UART TX write port; emits isolated one-cycle writes.
// Optional per-grant burst limit enabled by UART_TX_ARB_BURST_LIMIT_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
`ifdef UART_TX_ARB_BURST_LIMIT_EN
  , parameter int MAX_BURST = 4
`endif
) (
  input  logic                          uart_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          flush,
  input  logic                          tx_full,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_en
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_r;
  logic [IDX_W-1:0]       last_r;
  logic [IDX_W-1:0]       win_idx_r;
  logic [NUM_REQ-1:0]     pick_oh_s;
  logic [IDX_W-1:0]       pick_idx_s;
  logic                   pick_any_s;
  logic [DATA_WIDTH-1:0]  pick_data_s;
  logic [DATA_WIDTH-1:0]  win_data_s;
  logic                   limit_hit_s;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid  (req_valid),
    .last       (last_r),
    .winner_oh  (pick_oh_s),
    .winner_idx (pick_idx_s),
    .any_valid  (pick_any_s)
  );

  assign pick_data_s = req_data[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
  assign win_data_s  = req_data[win_idx_r*DATA_WIDTH +: DATA_WIDTH];

`ifdef UART_TX_ARB_BURST_LIMIT_EN
  localparam int CNT_W = burst_cnt_width(MAX_BURST);
  logic [CNT_W-1:0] count_r;
  assign limit_hit_s = (count_r >= CNT_W'(MAX_BURST));
`else
  assign limit_hit_s = 1'b0;
`endif

  // Arbitration FSM; all port outputs are registered here so they change only on edges.
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ARB_IDLE;
      last_r    <= IDX_W'(NUM_REQ - 1);
      win_idx_r <= '0;
      grant     <= '0;
      req_ready <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
`ifdef UART_TX_ARB_BURST_LIMIT_EN
      count_r   <= '0;
`endif
    end else if (flush) begin
      if (state_r != ARB_IDLE) begin
        last_r <= win_idx_r;
      end else begin
        last_r <= last_r;
      end
      state_r   <= ARB_IDLE;
      grant     <= '0;
      req_ready <= '0;
      wr_en     <= 1'b0;
`ifdef UART_TX_ARB_BURST_LIMIT_EN
      count_r   <= '0;
`endif
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pick_any_s && !tx_full) begin
            state_r   <= ARB_WRITE;
            grant     <= pick_oh_s;
            win_idx_r <= pick_idx_s;
            wr_data   <= pick_data_s;
            wr_en     <= 1'b1;
            req_ready <= pick_oh_s;
`ifdef UART_TX_ARB_BURST_LIMIT_EN
            count_r   <= CNT_W'(1);
`endif
          end else begin
            wr_en     <= 1'b0;
            req_ready <= '0;
          end
        end
        ARB_WRITE: begin
          state_r   <= ARB_GAP;
          wr_en     <= 1'b0;
          req_ready <= '0;
        end
        ARB_GAP: begin
          // tx_full here already accounts for the write issued in ARB_WRITE.
          if (req_valid[win_idx_r] && !tx_full && !limit_hit_s) begin
            state_r   <= ARB_WRITE;
            wr_data   <= win_data_s;
            wr_en     <= 1'b1;
            req_ready <= grant;
`ifdef UART_TX_ARB_BURST_LIMIT_EN
            count_r   <= count_r + CNT_W'(1);
`endif
          end else begin
            state_r   <= ARB_IDLE;
            last_r    <= win_idx_r;
            grant     <= '0;
            wr_en     <= 1'b0;
            req_ready <= '0;
`ifdef UART_TX_ARB_BURST_LIMIT_EN
            count_r   <= '0;
`endif
          end
        end
        default: begin
          state_r   <= ARB_IDLE;
          grant     <= '0;
          wr_en     <= 1'b0;
          req_ready <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8).
module tb_uart_tx_arbiter;

  logic        uart_clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        flush;
  logic        tx_full;
  logic [7:0]  wr_data;
  logic        wr_en;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter dut (
    .uart_clk  (uart_clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant     (grant),
    .flush     (flush),
    .tx_full   (tx_full),
    .wr_data   (wr_data),
    .wr_en     (wr_en)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] data;
    logic        tx;
    logic        fl;
    logic        en;
    logic [7:0]  wd;
    logic [3:0]  rdy;
    logic [3:0]  gr;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return -1;
  endfunction

  initial begin
    int nw;
    int prev_en;
    int gi;
    int exp_idx;
    int cyc;

    vecs[0]  = '{4'h1, 32'h00000041, 1'b0, 1'b0, 1'b1, 8'h41, 4'h1, 4'h1};
    vecs[1]  = '{4'h1, 32'h00000042, 1'b0, 1'b0, 1'b0, 8'h41, 4'h0, 4'h1};
    vecs[2]  = '{4'h1, 32'h00000042, 1'b0, 1'b0, 1'b1, 8'h42, 4'h1, 4'h1};
    vecs[3]  = '{4'h1, 32'h00000043, 1'b0, 1'b0, 1'b0, 8'h42, 4'h0, 4'h1};
    vecs[4]  = '{4'h1, 32'h00000043, 1'b0, 1'b0, 1'b1, 8'h43, 4'h1, 4'h1};
    vecs[5]  = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'h43, 4'h0, 4'h1};
    vecs[6]  = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'h43, 4'h0, 4'h0};
    vecs[7]  = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'h43, 4'h0, 4'h0};
    vecs[8]  = '{4'h4, 32'h00770000, 1'b1, 1'b0, 1'b0, 8'h43, 4'h0, 4'h0};
    vecs[9]  = '{4'h4, 32'h00770000, 1'b1, 1'b0, 1'b0, 8'h43, 4'h0, 4'h0};
    vecs[10] = '{4'h4, 32'h00770000, 1'b0, 1'b0, 1'b1, 8'h77, 4'h4, 4'h4};
    vecs[11] = '{4'h4, 32'h00780000, 1'b1, 1'b0, 1'b0, 8'h77, 4'h0, 4'h4};
    vecs[12] = '{4'h4, 32'h00780000, 1'b1, 1'b0, 1'b0, 8'h77, 4'h0, 4'h0};
    vecs[13] = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'h77, 4'h0, 4'h0};
    vecs[14] = '{4'hA, 32'h33001100, 1'b0, 1'b0, 1'b1, 8'h33, 4'h8, 4'h8};
    vecs[15] = '{4'h2, 32'h00001100, 1'b0, 1'b0, 1'b0, 8'h33, 4'h0, 4'h8};
    vecs[16] = '{4'h2, 32'h00001100, 1'b0, 1'b0, 1'b0, 8'h33, 4'h0, 4'h0};
    vecs[17] = '{4'h2, 32'h00001100, 1'b0, 1'b0, 1'b1, 8'h11, 4'h2, 4'h2};
    vecs[18] = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'h11, 4'h0, 4'h2};
    vecs[19] = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'h11, 4'h0, 4'h0};
    vecs[20] = '{4'h2, 32'h00002100, 1'b0, 1'b0, 1'b1, 8'h21, 4'h2, 4'h2};
    vecs[21] = '{4'h2, 32'h00002200, 1'b0, 1'b0, 1'b0, 8'h21, 4'h0, 4'h2};
    vecs[22] = '{4'h2, 32'h00002200, 1'b0, 1'b0, 1'b1, 8'h22, 4'h2, 4'h2};
    vecs[23] = '{4'h2, 32'h00002300, 1'b0, 1'b1, 1'b0, 8'h22, 4'h0, 4'h0};
    vecs[24] = '{4'h6, 32'h00552300, 1'b0, 1'b0, 1'b1, 8'h55, 4'h4, 4'h4};
    vecs[25] = '{4'h2, 32'h00002300, 1'b0, 1'b0, 1'b0, 8'h55, 4'h0, 4'h4};
    vecs[26] = '{4'h2, 32'h00002300, 1'b0, 1'b0, 1'b0, 8'h55, 4'h0, 4'h0};
    vecs[27] = '{4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'h55, 4'h0, 4'h0};

    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_data  = 32'h0;
    flush     = 1'b0;
    tx_full   = 1'b0;
    #23;
    check("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check("reset_wr_data", {24'd0, wr_data}, 32'd0);
    check("reset_req_ready", {28'd0, req_ready}, 32'd0);
    check("reset_grant", {28'd0, grant}, 32'd0);
    @(negedge uart_clk);
    rst_n = 1'b1;

    // Table: inputs for one cycle, outputs checked just after the edge.
    for (int i = 0; i < 28; i++) begin
      @(negedge uart_clk);
      req_valid = vecs[i].rv;
      req_data  = vecs[i].data;
      tx_full   = vecs[i].tx;
      flush     = vecs[i].fl;
      @(posedge uart_clk);
      #1;
      check($sformatf("v%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vecs[i].en});
      check($sformatf("v%0d_wr_data", i), {24'd0, wr_data}, {24'd0, vecs[i].wd});
      check($sformatf("v%0d_req_ready", i), {28'd0, req_ready}, {28'd0, vecs[i].rdy});
      check($sformatf("v%0d_grant", i), {28'd0, grant}, {28'd0, vecs[i].gr});
    end

    // Reset asserted while a write is on the port clears outputs immediately.
    @(negedge uart_clk);
    flush     = 1'b0;
    tx_full   = 1'b0;
    req_valid = 4'h8;
    req_data  = 32'hAB000000;
    @(posedge uart_clk);
    #1;
    check("rst_pre_wr_en", {31'd0, wr_en}, 32'd1);
    check("rst_pre_grant", {28'd0, grant}, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_async_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_async_grant", {28'd0, grant}, 32'd0);

    // All requesters continuously valid; grant order depends on burst limit.
    @(negedge uart_clk);
    rst_n     = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'hA3A2A1A0;
    nw      = 0;
    prev_en = 0;
    cyc     = 0;
    while (cyc < 120 && nw < 20) begin
      @(posedge uart_clk);
      #1;
      cyc++;
      if (wr_en) begin
        gi = oh2idx(grant);
`ifdef UART_TX_ARB_BURST_LIMIT_EN
        exp_idx = (nw / 4) % 4;
`else
        exp_idx = 0;
`endif
        check($sformatf("burst%0d_owner", nw), gi, exp_idx);
        check($sformatf("burst%0d_data", nw), {24'd0, wr_data}, 32'hA0 + exp_idx);
        check($sformatf("burst%0d_ready", nw), {28'd0, req_ready}, {28'd0, grant});
        check($sformatf("burst%0d_gap", nw), prev_en, 0);
        nw++;
      end
      prev_en = int'(wr_en);
    end
    check("burst_writes", nw, 20);

    // Dropping all requests releases the grant within a bounded number of cycles.
    @(negedge uart_clk);
    req_valid = 4'h0;
    cyc = 0;
    while (cyc < 10 && grant != 4'h0) begin
      @(posedge uart_clk);
      #1;
      cyc++;
    end
    check("release_grant", {28'd0, grant}, 32'd0);
    check("release_wr_en", {31'd0, wr_en}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single write port of the UART TX path among `NUM_REQ` byte-stream requesters, such as the register block, a DMA engine and a debug console. It sits in the `uart_clk` domain directly ahead of the TX path. It drives that path's `wr_data`/`wr_en` as one-cycle write pulses separated by at least one low cycle, as required by the path's rising-edge write detection. It never writes while the TX FIFO reports full.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: byte width.
- `MAX_BURST`, 4: maximum bytes per grant. Used only when `UART_TX_ARB_BURST_LIMIT_EN` is defined.
- `uart_clk`  in  1: clock. Single clock domain.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  NUM_REQ: requester `i` has a byte on its lane.
- `req_data`  in  NUM_REQ*DATA_WIDTH: flattened lanes; lane `i` is bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  NUM_REQ: one-cycle pulse; the byte on lane `i` has been accepted.
- `grant`  out  NUM_REQ: one-hot current owner; all zero when idle.
- `flush`  in  1: synchronous abort of the current burst.
- `tx_full`  in  1: TX FIFO full, from the TX path.
- `wr_data`  out  DATA_WIDTH: to TX path.
- `wr_en`  out  1: to TX path.

## Operation
- Requester protocol: hold `req_valid` and the lane data stable until `req_ready` pulses. The requester may then present the next byte or drop `req_valid`.
- Round-robin pointer `last` holds the index of the previous winner; reset value is `NUM_REQ-1`, so requester 0 has first priority.
- Selection: search from `last+1` upward, wrapping modulo `NUM_REQ`. The first requester with `req_valid` high wins.
- FSM states: `ARB_IDLE`, `ARB_WRITE`, `ARB_GAP`.
- `ARB_IDLE`:
  - If any `req_valid` is high and `tx_full` is low: register the one-hot winner into `grant`, capture its lane into `wr_data`, set the burst count to 1, go to `ARB_WRITE`.
  - Otherwise stay in `ARB_IDLE`.
- `ARB_WRITE`: `wr_en`=1 and `req_ready[winner]`=1 for exactly this cycle. Always go to `ARB_GAP`.
- `ARB_GAP`: `wr_en`=0. The `tx_full` seen here already reflects the write just issued.
  - If `req_valid[winner]` is high, `tx_full` is low and the burst limit is not reached: capture the lane, increment the count, go to `ARB_WRITE`.
  - Otherwise: set `last`=winner, clear `grant`, go to `ARB_IDLE`.
- Consequence: the arbiter never writes into a full FIFO. `tx_full` is sampled only in `ARB_IDLE`/`ARB_GAP`, one cycle after the previous write.
- `flush`:
  - In any state, at the next edge: go to `ARB_IDLE`, `wr_en`=0, `grant`=0, no `req_ready` pulse.
  - If a burst was active, set `last`=winner.
  - `flush` has priority over all other transitions.
- Simultaneous events:
  - Requester drops `req_valid` in `ARB_GAP`: ends its burst.
  - New requests arriving mid-burst wait until the grant is released.
- Burst counter width is `$clog2(MAX_BURST+1)`. It saturates and never wraps.

## Timing
- Reset values: `wr_en`=0, `wr_data`=0, `req_ready`=0, `grant`=0, state `ARB_IDLE`, `last`=`NUM_REQ-1`, burst count 0.
- Latency: `req_valid` high in an `ARB_IDLE` cycle gives `wr_en` high in the next cycle.
- Peak throughput: one byte per 2 cycles.
- `req_ready` is coincident with `wr_en`.
- In a back-to-back burst, the next byte must be on the lane during the `ARB_GAP` cycle. It is captured at the `ARB_GAP`→`ARB_WRITE` edge.
- After a grant is released, the minimum is one `ARB_IDLE` cycle before the next grant.
- Outputs `wr_en`, `wr_data`, `req_ready` and `grant` are registered.

## Configuration
- `UART_TX_ARB_BURST_LIMIT_EN` defined: a grant is released after `MAX_BURST` accepted bytes even if the requester stays valid. The pointer advances, so other valid requesters are served next.
- Macro undefined: a grant is held until the requester drops `req_valid` in `ARB_GAP`, `tx_full` is high in `ARB_GAP`, or `flush`. `MAX_BURST` and the burst counter are not built.

## Structure
- Package `uart_tx_arb_pkg` contains:
  - the `arb_state_e` enum (`ARB_IDLE`, `ARB_WRITE`, `ARB_GAP`);
  - a function computing the burst counter width.
- Sub-module `uart_rr_pick`: purely combinational. Inputs are `req_valid` and `last`; outputs are the one-hot winner, the winner index and `any_valid`.

## Test plan
- Requester 0 only, bytes 0x41, 0x42, 0x43 held back-to-back → `wr_en` high in cycles 1, 3, 5 after the first `ARB_IDLE`; `wr_data` 0x41/0x42/0x43; three `req_ready[0]` pulses; `grant` returns to 0.
- All four requesters continuously valid, macro defined, `MAX_BURST`=4 → 4 bytes each in grant order 0, 1, 2, 3, 0. Macro undefined → requester 0 owns the port until it drops `req_valid`.
- `tx_full` high with requester 2 valid → no `wr_en`. `tx_full` falls → `wr_en` within 2 cycles. `tx_full` rising after a write in a burst → grant is released in `ARB_GAP`.
- `last`=2, requesters 1 and 3 go valid in the same cycle → 3 wins. Next grant goes to 1.
- `flush` asserted in `ARB_WRITE` mid-burst of requester 1 → next cycle `wr_en`=0, `grant`=0, `last`=1. A subsequent request from 1 and 2 grants 2.
- `rst_n` low during `ARB_WRITE` → `wr_en`, `req_ready` and `grant` go to 0 immediately. After release, requester 0 has priority.
